// File: rtl/fruit_collision_detector_if.sv
// Scan-side and report-side signals of the fruit collision detector, bundled
// so the detector and its neighbours share one port declaration.
interface fruit_collision_detector_if #(
   parameter int NUM_FRUITS = 5,
   parameter int COUNT_W    = 3
);
   logic                         startOfFrame;
   logic [10:0]                  pixelX;
   logic [10:0]                  pixelY;
   logic                         monkeyDrawingRequest;
   logic [NUM_FRUITS-1:0][10:0]  topLeftX;
   logic [NUM_FRUITS-1:0][10:0]  topLeftY;
   logic [NUM_FRUITS-1:0]        drawFruit;
   logic [NUM_FRUITS-1:0]        monkeyCollision;
   logic                         scorePulse;
   logic [COUNT_W-1:0]           eatenCount;

   modport master (
      output startOfFrame, pixelX, pixelY, monkeyDrawingRequest,
             topLeftX, topLeftY, drawFruit,
      input  monkeyCollision, scorePulse, eatenCount
   );

   modport slave (
      input  startOfFrame, pixelX, pixelY, monkeyDrawingRequest,
             topLeftX, topLeftY, drawFruit,
      output monkeyCollision, scorePulse, eatenCount
   );
endinterface

// File: rtl/fruit_collision_detector.sv
// Per-pixel monkey/fruit overlap detector: latches hits during the scan and
// reports each newly eaten fruit once, in the cycle after startOfFrame.
module fruit_collision_detector #(
   parameter int NUM_FRUITS   = 5,
   parameter int FRUIT_WIDTH  = 32,
   parameter int FRUIT_HEIGHT = 32,
   parameter int COUNT_W      = 3
) (
   input  logic clk,
   input  logic reset,
   fruit_collision_detector_if.slave bus
);
   localparam logic [1:0] ST_ARMED    = 2'd0;
   localparam logic [1:0] ST_HIT      = 2'd1;
   localparam logic [1:0] ST_REPORTED = 2'd2;

   localparam int SUM_W = COUNT_W + $clog2(NUM_FRUITS + 1) + 1;
   localparam logic [SUM_W-1:0] SAT_MAX = SUM_W'((1 << COUNT_W) - 1);
   localparam logic signed [12:0] W_OFS = 13'(FRUIT_WIDTH - 1);
   localparam logic signed [12:0] H_OFS = 13'(FRUIT_HEIGHT - 1);

   logic signed [12:0]     w_px;
   logic signed [12:0]     w_py;
   logic [NUM_FRUITS-1:0]  w_is_hit;
   logic [NUM_FRUITS-1:0]  r_collision;
   logic                   r_score;
   logic [COUNT_W-1:0]     r_count;
   logic [SUM_W-1:0]       w_pop;
   logic [SUM_W-1:0]       w_sum;
   logic [COUNT_W-1:0]     w_count_next;

   // Pixel coordinates are unsigned, fruit corners signed: widen both to 13 bits
   // so boxes hanging off the left/top edge compare correctly without wrapping.
   assign w_px = $signed({2'b00, bus.pixelX});
   assign w_py = $signed({2'b00, bus.pixelY});

   genvar gi;
   generate
      for (gi = 0; gi < NUM_FRUITS; gi++) begin : g_fruit
         logic signed [12:0] w_left;
         logic signed [12:0] w_top;
         logic               w_box_hit;
         logic [1:0]         r_state;

         assign w_left    = $signed({{2{bus.topLeftX[gi][10]}}, bus.topLeftX[gi]});
         assign w_top     = $signed({{2{bus.topLeftY[gi][10]}}, bus.topLeftY[gi]});
         assign w_box_hit = bus.drawFruit[gi] & bus.monkeyDrawingRequest
                          & (w_px >= w_left) & (w_px <= w_left + W_OFS)
                          & (w_py >= w_top)  & (w_py <= w_top + H_OFS);

         always_ff @(posedge clk) begin
            if (reset) begin
               r_state <= ST_ARMED;
            end else begin
               case (r_state)
                  ST_ARMED:    if (w_box_hit && !bus.startOfFrame) r_state <= ST_HIT;
                  ST_HIT:      if (bus.startOfFrame) r_state <= ST_REPORTED;
                  // Re-arm only once the placement block has removed the fruit.
                  ST_REPORTED: if (!bus.drawFruit[gi]) r_state <= ST_ARMED;
                  default:     r_state <= ST_ARMED;
               endcase
            end
         end

         assign w_is_hit[gi] = (r_state == ST_HIT);
      end
   endgenerate

   always_comb begin
      w_pop = '0;
      for (int k = 0; k < NUM_FRUITS; k++) begin
         w_pop = w_pop + SUM_W'(r_collision[k]);
      end
      w_sum        = SUM_W'(r_count) + w_pop;
      w_count_next = (w_sum > SAT_MAX) ? '1 : w_sum[COUNT_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_collision <= '0;
         r_score     <= 1'b0;
         r_count     <= '0;
      end else begin
         r_collision <= bus.startOfFrame ? w_is_hit : '0;
         r_score     <= bus.startOfFrame & (|w_is_hit);
         r_count     <= w_count_next;
      end
   end

   assign bus.monkeyCollision = r_collision;
   assign bus.scorePulse      = r_score;
   assign bus.eatenCount      = r_count;
endmodule
